// File: rtl/dac_spi_pkg.sv
// Shared types and helpers for the DAC SPI transmitter.
package dac_spi_pkg;

  localparam int FRAME_BITS = 24;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    SHIFT,
    GAP,
    LDAC
  } state_t;

  // Signed two's complement sample to the DAC's offset-binary code.
  function automatic logic [15:0] twos_to_offset(input logic [15:0] s);
    return {~s[15], s[14:0]};
  endfunction

endpackage

// File: rtl/spi_frame_shifter.sv
// Serialises one FRAME_BITS word MSB first: SCLK high for the first half of
// each bit, low for the second; SYNCn low only while the frame is on the wire.
module spi_frame_shifter
  import dac_spi_pkg::*;
#(
  parameter int CLK_DIV = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [FRAME_BITS-1:0] frame,
  output logic                  done,
  output logic                  sclk,
  output logic                  sdo,
  output logic                  syncn
);

  localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);
  localparam logic [4:0] BIT_LAST = 5'(FRAME_BITS - 1);

  logic [FRAME_BITS-1:0] shreg_reg;
  logic [3:0]            div_reg;
  logic [4:0]            bit_reg;
  logic                  active_reg;
  logic                  sclk_reg;
  logic                  sdo_reg;
  logic                  phase_end;

  assign phase_end = (div_reg == DIV_LAST);
  // Last cycle of the low half of the final bit: SYNCn rises on the next edge.
  assign done  = active_reg && phase_end && !sclk_reg && (bit_reg == BIT_LAST);
  assign sclk  = sclk_reg;
  assign sdo   = sdo_reg;
  assign syncn = ~active_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_reg  <= '0;
      div_reg    <= '0;
      bit_reg    <= '0;
      active_reg <= 1'b0;
      sclk_reg   <= 1'b0;
      sdo_reg    <= 1'b0;
    end else if (start) begin
      shreg_reg  <= {frame[FRAME_BITS-2:0], 1'b0};
      sdo_reg    <= frame[FRAME_BITS-1];
      sclk_reg   <= 1'b1;
      active_reg <= 1'b1;
      div_reg    <= '0;
      bit_reg    <= '0;
    end else if (active_reg) begin
      if (phase_end) begin
        div_reg <= '0;
        if (sclk_reg) begin
          sclk_reg <= 1'b0;
        end else if (bit_reg == BIT_LAST) begin
          active_reg <= 1'b0;
          sdo_reg    <= 1'b0;
        end else begin
          sclk_reg  <= 1'b1;
          sdo_reg   <= shreg_reg[FRAME_BITS-1];
          shreg_reg <= {shreg_reg[FRAME_BITS-2:0], 1'b0};
          bit_reg   <= bit_reg + 5'd1;
        end
      end else begin
        div_reg <= div_reg + 4'd1;
      end
    end
  end

endmodule

// File: rtl/dac_spi_tx.sv
// Stereo sample to dual-channel DAC SPI writer (L -> channel A, R -> channel B).
// Define DAC_SPI_LDAC_EN to pulse LDACn after both frames; otherwise LDACn is held low.
module dac_spi_tx
  import dac_spi_pkg::*;
#(
  parameter int         CLK_DIV  = 1,
  parameter int         GAP_CYC  = 2,
  parameter int         LDAC_CYC = 2,
  parameter logic [7:0] CMD_A    = 8'h18,
  parameter logic [7:0] CMD_B    = 8'h19
) (
  input  logic        mck_i,
  input  logic        rst_i,
  input  logic [15:0] sample_l_i,
  input  logic [15:0] sample_r_i,
  input  logic        sample_vld_i,
  output logic        ready_o,
  output logic        busy_o,
  output logic        overrun_o,
  output logic        spi_sclk_o,
  output logic        spi_sdo_o,
  output logic        spi_syncn_o,
  output logic        spi_ldacn_o
);

  state_t                state_reg, state_next;
  logic [15:0]           code_a_reg, code_b_reg;
  logic                  chan_b_reg;
  logic [7:0]            cnt_reg;
  logic                  overrun_reg;
  logic                  accept;
  logic                  start;
  logic                  shift_done;
  logic [FRAME_BITS-1:0] frame;

  assign accept = sample_vld_i && (state_reg == IDLE);

  always_ff @(posedge mck_i or negedge rst_i) begin
    if (!rst_i) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_ff @(posedge mck_i or negedge rst_i) begin
    if (!rst_i) begin
      code_a_reg  <= '0;
      code_b_reg  <= '0;
      chan_b_reg  <= 1'b0;
      cnt_reg     <= '0;
      overrun_reg <= 1'b0;
    end else begin
      if (accept) begin
        code_a_reg <= twos_to_offset(sample_l_i);
        code_b_reg <= twos_to_offset(sample_r_i);
      end
      if (sample_vld_i && state_reg != IDLE) overrun_reg <= 1'b1;
      if (state_reg == LOAD_A) chan_b_reg <= 1'b0;
      if (state_reg == LOAD_B) chan_b_reg <= 1'b1;
      // Dwell counter for GAP/LDAC, restarted on every state change.
      if (state_next != state_reg)                    cnt_reg <= '0;
      else if (state_reg == GAP || state_reg == LDAC) cnt_reg <= cnt_reg + 8'd1;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:           if (sample_vld_i) state_next = LOAD_A;
      LOAD_A, LOAD_B: state_next = SHIFT;
      SHIFT:          if (shift_done) state_next = GAP;
      GAP: begin
        if (cnt_reg == 8'(GAP_CYC - 1)) begin
`ifdef DAC_SPI_LDAC_EN
          state_next = chan_b_reg ? LDAC : LOAD_B;
`else
          state_next = chan_b_reg ? IDLE : LOAD_B;
`endif
        end
      end
      LDAC:           if (cnt_reg == 8'(LDAC_CYC - 1)) state_next = IDLE;
      default:        state_next = IDLE;
    endcase
  end

  always_comb begin
    start   = (state_reg == LOAD_A) || (state_reg == LOAD_B);
    frame   = (state_reg == LOAD_B) ? {CMD_B, code_b_reg} : {CMD_A, code_a_reg};
    ready_o = (state_reg == IDLE);
  end

  assign busy_o    = ~ready_o;
  assign overrun_o = overrun_reg;

`ifdef DAC_SPI_LDAC_EN
  assign spi_ldacn_o = (state_reg != LDAC);
`else
  // Both channels update on their own frame; LDACn is only released in reset.
  assign spi_ldacn_o = ~rst_i;
`endif

  spi_frame_shifter #(
    .CLK_DIV (CLK_DIV)
  ) u_shifter (
    .clk   (mck_i),
    .rst_n (rst_i),
    .start (start),
    .frame (frame),
    .done  (shift_done),
    .sclk  (spi_sclk_o),
    .sdo   (spi_sdo_o),
    .syncn (spi_syncn_o)
  );

endmodule

// File: tb/tb_dac_spi_tx.sv
// Directed bench for dac_spi_tx: decodes the SPI pins back into frames and timing counts.
module tb_dac_spi_tx;

`ifdef DAC_SPI_LDAC_EN
  localparam int BUSY1 = 104;
  localparam int BUSY3 = 296;
  localparam int LDAC1 = 2;
  localparam logic LDAC_IDLE = 1'b1;
`else
  localparam int BUSY1 = 102;
  localparam int BUSY3 = 294;
  localparam int LDAC1 = 102;
  localparam logic LDAC_IDLE = 1'b0;
`endif

  logic        mck = 1'b0;
  logic        rst_i = 1'b1;
  logic [15:0] sample_l = '0;
  logic [15:0] sample_r = '0;
  logic        vld1 = 1'b0;
  logic        vld3 = 1'b0;
  logic        rdy1, busy1, ovr1, sclk1, sdo1, syncn1, ldacn1;
  logic        rdy3, busy3, ovr3, sclk3, sdo3, syncn3, ldacn3;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [23:0] cap_fa, cap_fb;
  int cap_nfr, cap_low_a, cap_low_b, cap_between, cap_ldac, cap_busy;
  int cap_hi, cap_hirun, cap_nfall, cap_viol, cap_first_low, cap_timeout;

  always #5 mck = ~mck;
  always @(posedge mck) cyc <= cyc + 1;

  dac_spi_tx u_dut1 (
    .mck_i(mck), .rst_i(rst_i), .sample_l_i(sample_l), .sample_r_i(sample_r),
    .sample_vld_i(vld1), .ready_o(rdy1), .busy_o(busy1), .overrun_o(ovr1),
    .spi_sclk_o(sclk1), .spi_sdo_o(sdo1), .spi_syncn_o(syncn1), .spi_ldacn_o(ldacn1)
  );

  dac_spi_tx #(.CLK_DIV(3)) u_dut3 (
    .mck_i(mck), .rst_i(rst_i), .sample_l_i(sample_l), .sample_r_i(sample_r),
    .sample_vld_i(vld3), .ready_o(rdy3), .busy_o(busy3), .overrun_o(ovr3),
    .spi_sclk_o(sclk3), .spi_sdo_o(sdo3), .spi_syncn_o(syncn3), .spi_ldacn_o(ldacn3)
  );

  task automatic do_reset();
    @(negedge mck);
    rst_i = 1'b0;
    repeat (2) @(negedge mck);
    rst_i = 1'b1;
    @(negedge mck);
  endtask

  // Strobe is accepted on the posedge between the two negedges; inputs then scrambled.
  task automatic strobe(input bit sel, input logic [15:0] l, input logic [15:0] r);
    @(negedge mck);
    sample_l = l;
    sample_r = r;
    if (sel) vld3 = 1'b1; else vld1 = 1'b1;
    @(negedge mck);
    vld1 = 1'b0;
    vld3 = 1'b0;
    sample_l = 16'hDEAD;
    sample_r = 16'hBEEF;
  endtask

  // Samples the pins every negedge while busy; index 0 is the LOAD_A cycle.
  task automatic capture(input bit sel);
    logic sclk, sdo, syncn, ldacn, busy, psclk, psyncn, fin;
    logic [23:0] sh;
    int idx, run;
    cap_fa = '0; cap_fb = '0; cap_nfr = 0; cap_low_a = 0; cap_low_b = 0;
    cap_between = 0; cap_ldac = 0; cap_busy = 0; cap_hi = 0; cap_hirun = 0;
    cap_nfall = 0; cap_viol = 0; cap_first_low = -1; cap_timeout = 0;
    psclk = 1'b0; psyncn = 1'b1; sh = '0; idx = 0; run = 0; fin = 1'b0;
    while (!fin) begin
      sclk  = sel ? sclk3  : sclk1;
      sdo   = sel ? sdo3   : sdo1;
      syncn = sel ? syncn3 : syncn1;
      ldacn = sel ? ldacn3 : ldacn1;
      busy  = sel ? busy3  : busy1;
      if (!psyncn && syncn) begin
        if (cap_nfr == 0) cap_fa = sh; else cap_fb = sh;
        cap_nfr++;
        sh = '0;
      end
      if (!busy) begin
        fin = 1'b1;
      end else begin
        cap_busy++;
        if (!ldacn) cap_ldac++;
        if (!syncn) begin
          if (cap_first_low < 0) cap_first_low = idx;
          if (cap_nfr == 0) cap_low_a++; else cap_low_b++;
          if (sclk) begin
            cap_hi++;
            run++;
            if (run > cap_hirun) cap_hirun = run;
          end else begin
            run = 0;
          end
          if (psclk && !sclk) begin
            sh = {sh[22:0], sdo};
            cap_nfall++;
          end
        end else begin
          run = 0;
          if (sclk || sdo) cap_viol++;
          if (cap_nfr == 1) cap_between++;
        end
        psclk = sclk;
        psyncn = syncn;
        idx++;
        if (idx > 3000) begin
          cap_timeout = 1;
          fin = 1'b1;
        end else begin
          @(negedge mck);
        end
      end
    end
    $display("txn dut=%0d frameA=%06h frameB=%06h frames=%0d busy=%0d", sel ? 3 : 1,
             cap_fa, cap_fb, cap_nfr, cap_busy);
  endtask

  task automatic test_reset();
    #2 rst_i = 1'b0;
    #1;
    checks++; if ({sclk1, sdo1, syncn1, ldacn1} !== 4'b0011) begin errors++;
      $display("FAIL reset_spi: got sclk,sdo,syncn,ldacn=%b want 0011", {sclk1, sdo1, syncn1, ldacn1}); end
    checks++; if ({rdy1, busy1, ovr1} !== 3'b100) begin errors++;
      $display("FAIL reset_flags: got rdy,busy,ovr=%b want 100", {rdy1, busy1, ovr1}); end
    repeat (3) @(negedge mck);
    rst_i = 1'b1;
    repeat (3) @(negedge mck);
    checks++; if (ldacn1 !== LDAC_IDLE) begin errors++;
      $display("FAIL idle_ldacn: got %b want %b", ldacn1, LDAC_IDLE); end
    checks++; if ({rdy1, syncn1, sclk1} !== 3'b110) begin errors++;
      $display("FAIL idle_state: got rdy,syncn,sclk=%b want 110", {rdy1, syncn1, sclk1}); end
  endtask

  task automatic test_basic();
    strobe(0, 16'h8000, 16'h7FFF);
    capture(0);
    checks++; if (cap_timeout !== 0 || cap_nfr !== 2) begin errors++;
      $display("FAIL basic_frames: got count=%0d timeout=%0d want 2/0", cap_nfr, cap_timeout); end
    checks++; if (cap_fa !== 24'h180000) begin errors++;
      $display("FAIL basic_frame_a: got %06h want 180000", cap_fa); end
    checks++; if (cap_fb !== 24'h19FFFF) begin errors++;
      $display("FAIL basic_frame_b: got %06h want 19ffff", cap_fb); end
    checks++; if (cap_low_a !== 48 || cap_low_b !== 48) begin errors++;
      $display("FAIL basic_syncn_low: got %0d/%0d want 48/48", cap_low_a, cap_low_b); end
    checks++; if (cap_between !== 3) begin errors++;
      $display("FAIL basic_gap: got %0d want 3 (gap 2 + load 1)", cap_between); end
    checks++; if (cap_ldac !== LDAC1) begin errors++;
      $display("FAIL basic_ldac: got %0d want %0d", cap_ldac, LDAC1); end
    checks++; if (cap_busy !== BUSY1) begin errors++;
      $display("FAIL basic_busy: got %0d want %0d", cap_busy, BUSY1); end
    checks++; if (cap_first_low !== 1) begin errors++;
      $display("FAIL basic_latency: got %0d want 1", cap_first_low); end
    checks++; if (cap_nfall !== 48 || cap_hi !== 48 || cap_hirun !== 1 || cap_viol !== 0) begin errors++;
      $display("FAIL basic_sclk: got fall=%0d hi=%0d run=%0d viol=%0d want 48/48/1/0",
               cap_nfall, cap_hi, cap_hirun, cap_viol); end
  endtask

  task automatic test_clkdiv();
    strobe(1, 16'h0000, 16'hFFFF);
    capture(1);
    checks++; if (cap_fa !== 24'h188000 || cap_fb !== 24'h197FFF) begin errors++;
      $display("FAIL div3_frames: got %06h %06h want 188000 197fff", cap_fa, cap_fb); end
    checks++; if (cap_low_a !== 144 || cap_low_b !== 144) begin errors++;
      $display("FAIL div3_syncn_low: got %0d/%0d want 144/144", cap_low_a, cap_low_b); end
    checks++; if (cap_hirun !== 3 || cap_hi !== 144 || cap_nfall !== 48) begin errors++;
      $display("FAIL div3_sclk: got run=%0d hi=%0d fall=%0d want 3/144/48", cap_hirun, cap_hi, cap_nfall); end
    checks++; if (cap_busy !== BUSY3 || cap_viol !== 0) begin errors++;
      $display("FAIL div3_busy: got %0d viol=%0d want %0d/0", cap_busy, cap_viol, BUSY3); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] ls [4];
    logic [15:0] rs [4];
    logic [23:0] ea [4];
    logic [23:0] eb [4];
    int t0;
    ls = '{16'h7FFE, 16'h7FFF, 16'h8000, 16'h8001};
    rs = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    ea = '{24'h18FFFE, 24'h18FFFF, 24'h180000, 24'h180001};
    eb = '{24'h197FFE, 24'h197FFF, 24'h198000, 24'h198001};
    do_reset();
    for (int k = 0; k < 4; k++) begin
      t0 = cyc;
      strobe(0, ls[k], rs[k]);
      capture(0);
      checks++; if (cap_fa !== ea[k] || cap_fb !== eb[k] || cap_nfr !== 2) begin errors++;
        $display("FAIL b2b_frame%0d: got %06h %06h n=%0d want %06h %06h n=2",
                 k, cap_fa, cap_fb, cap_nfr, ea[k], eb[k]); end
      while (cyc < t0 + 255) @(negedge mck);
    end
    checks++; if (ovr1 !== 1'b0) begin errors++;
      $display("FAIL b2b_overrun: got %b want 0", ovr1); end
  endtask

  task automatic test_overrun(input int delay);
    int extra_busy;
    do_reset();
    checks++; if (ovr1 !== 1'b0) begin errors++;
      $display("FAIL ovr%0d_clear: got %b want 0", delay, ovr1); end
    strobe(0, 16'h0100, 16'hFF00);
    fork
      capture(0);
      begin
        repeat (delay) @(negedge mck);
        sample_l = 16'h5555;
        sample_r = 16'hAAAA;
        vld1 = 1'b1;
        @(negedge mck);
        vld1 = 1'b0;
      end
    join
    checks++; if (cap_fa !== 24'h188100 || cap_fb !== 24'h197F00 || cap_busy !== BUSY1) begin errors++;
      $display("FAIL ovr%0d_txn: got %06h %06h busy=%0d want 188100 197f00 %0d",
               delay, cap_fa, cap_fb, cap_busy, BUSY1); end
    extra_busy = 0;
    repeat (10) begin
      @(negedge mck);
      if (busy1 || !syncn1) extra_busy++;
    end
    checks++; if (extra_busy !== 0) begin errors++;
      $display("FAIL ovr%0d_no_third: got %0d busy cycles want 0", delay, extra_busy); end
    checks++; if (ovr1 !== 1'b1) begin errors++;
      $display("FAIL ovr%0d_sticky: got %b want 1", delay, ovr1); end
  endtask

  task automatic test_midshift_reset();
    do_reset();
    strobe(0, 16'h1111, 16'h2222);
    repeat (21) @(negedge mck);
    checks++; if (syncn1 !== 1'b0) begin errors++;
      $display("FAIL mid_in_shift: got syncn=%b want 0", syncn1); end
    rst_i = 1'b0;
    #1;
    checks++; if ({sclk1, sdo1, syncn1, ldacn1, rdy1, busy1} !== 6'b001110) begin errors++;
      $display("FAIL mid_reset_outs: got sclk,sdo,syncn,ldacn,rdy,busy=%b want 001110",
               {sclk1, sdo1, syncn1, ldacn1, rdy1, busy1}); end
    @(negedge mck);
    rst_i = 1'b1;
    @(negedge mck);
    strobe(0, 16'h4321, 16'hBCDE);
    capture(0);
    checks++; if (cap_fa !== 24'h18C321 || cap_fb !== 24'h193CDE || cap_low_a !== 48 || cap_nfall !== 48) begin errors++;
      $display("FAIL mid_fresh: got %06h %06h low=%0d fall=%0d want 18c321 193cde 48 48",
               cap_fa, cap_fb, cap_low_a, cap_nfall); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_clkdiv();
    test_back_to_back();
    test_overrun(20);
    test_overrun(BUSY1 - 1);
    test_midshift_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
